fft4_stream_pp: RTL and testbench
=================================

# fft4_stream_pp

Parametrised streaming 4-point complex FFT/IFFT with valid/ready handshakes on both sides and a two-bank ping-pong result buffer. It accepts samples at up to one per cycle without gaps and drains results under downstream backpressure. It is the next-generation replacement for the fixed-width, non-backpressured 4-point FFT in the sample-processing datapath. Each frame is computed at full precision, so no scaling or overflow is possible.

## Interface
- IW, 8: input component width (signed two's complement), IW >= 2
- OW, IW+2: output component width; fixed at IW+2 (exact bit growth), not overridable
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample; sample accepted on in_valid && in_ready
- in_re, in_im  in  IW each  input sample, signed
- in_inv  in  1  0 = forward FFT, 1 = inverse (no 1/N scaling); sampled on the first sample of a frame only
- out_valid  out  1  output bin valid
- out_ready  in  1  downstream accepts; bin transferred on out_valid && out_ready
- out_re, out_im  out  OW each  output bin, signed
- out_idx  out  2  bin index 0..3 of the current output
- out_last  out  1  high with bin 3
- out_inv  out  1  mode the frame was computed in

## Operation
- Collector: 2-bit count plus 3 stored samples (a0..a2). An accepted sample with count 0..2 is stored and count increments. The 4th accepted sample (a3) is not stored: the frame is computed combinationally from a0..a2 and the live input, then written to bank[wr_ptr] on that same edge. count wraps to 0 and wr_ptr toggles.
- Mode: in_inv latched when count==0 and a sample is accepted; it applies to the whole frame and is stored with the bank.
- Arithmetic: sign-extend all components to OW before add/sub. With d0 = a0-a2 and d1 = a1-a3:
  - X0 = a0+a1+a2+a3
  - X2 = (a0+a2)-(a1+a3)
  - Forward: X1 = (d0.re+d1.im, d0.im-d1.re); X3 = (d0.re-d1.im, d0.im+d1.re)
  - Inverse: the X1 and X3 formulas are swapped (conjugate twiddle).
- Banks: 2 entries, each holding 4 complex results, a full flag and an inv bit. Banks are written in order wr_ptr and read in order rd_ptr, so frames always leave in input order.
- in_ready = !(count==3 && bank[wr_ptr].full). It depends on registered state only.
- Reader: out_valid = bank[rd_ptr].full. The out_re/out_im/out_inv mux is selected by the registered rd_ptr and out_idx. No combinational path from any input to any output.
- On each transfer, out_idx increments. When out_idx==3 transfers, the bank's full flag clears, rd_ptr toggles and out_idx wraps to 0.
- Simultaneous write to one bank and free of the other on the same edge are both performed.
- A bank freed on edge E raises in_ready on the cycle after E (no same-cycle pass-through).

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_re=out_im=0 (bank contents cleared), out_idx=0, out_last=0, out_inv=0
  - count=0, wr_ptr=rd_ptr=0, both full flags 0
- Latency: when a3 is accepted on edge E with the queue empty, X0 is valid in the cycle after E. With out_ready held high, X0..X3 appear on 4 consecutive cycles.
- Throughput: continuous in_valid with out_ready=1 gives in_ready permanently 1 and gapless out_valid after the first frame.
- Capacity: 2 complete frames plus 3 samples of a third. in_ready drops only when a frame's 4th sample is pending and both banks are full.
- Reset asserted mid-frame or mid-output: on the next evaluation, all state returns to the reset values and partial frames are discarded. After release, the next 4 accepted samples form frame 0.
- in_valid/in_re/in_im/in_inv are don't-care while in_ready=0. out_* hold stable while out_valid && !out_ready.

## Test plan
- Reset: assert rst asynchronously with clk stopped -> in_ready=1, out_valid=0, out_re=out_im=0, out_idx=0.
- Forward, IW=8, inputs (1,0),(2,0),(3,0),(4,0) with in_inv=0 -> bins (10,0),(-2,2),(-2,0),(-2,-2); out_last only on bin 3; out_valid first in the cycle after the 4th accept.
- Inverse: same inputs with in_inv=1 on sample 0 and in_inv toggled on samples 1..3 -> bins (10,0),(-2,-2),(-2,0),(-2,2), out_inv=1.
- Extremes: four samples of (-128,-128) -> X0=(-512,-512), X1..X3=(0,0). Four samples of (127,-128) -> X0=(508,-512), others 0; no wrap.
- Backpressure: out_ready=0, in_valid=1 continuously -> 11 samples accepted, then in_ready=0. Raise out_ready -> in_ready=1 in the cycle after bin 3 of frame 0 transfers; frames 0,1,2 emerge in order with correct bins.
- Streaming plus mid-run reset: random frames at full rate with out_ready=1 -> match reference model with no gaps. Assert rst after 2 samples of a frame -> outputs reset; the next 4 samples yield a correct fresh frame.

Source files
------------

// File: rtl/fft4_stream_pp.sv
// Streaming 4-point complex FFT/IFFT: collects four samples, computes the frame
// exactly on the fourth accept and parks it in a two-bank ping-pong output buffer.
module fft4_stream_pp #(
  parameter int IW = 8,
  localparam int OW = IW + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_re,
  input  logic [IW-1:0] in_im,
  input  logic          in_inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_re,
  output logic [OW-1:0] out_im,
  output logic [1:0]    out_idx,
  output logic          out_last,
  output logic          out_inv
);

  logic [1:0]    count;
  logic [IW-1:0] a_re [3];
  logic [IW-1:0] a_im [3];
  logic          frame_inv;
  logic          wr_ptr, rd_ptr;
  logic [1:0]    rd_idx;
  logic [1:0]    full;
  logic [1:0]    bank_inv;
  logic [OW-1:0] bank_re [2][4];
  logic [OW-1:0] bank_im [2][4];

  logic [OW-1:0] s_re [4];
  logic [OW-1:0] s_im [4];
  logic [OW-1:0] x_re [4];
  logic [OW-1:0] x_im [4];
  logic [OW-1:0] e_re, e_im, o_re, o_im, d0_re, d0_im, d1_re, d1_im;
  logic [OW-1:0] p_re, p_im, m_re, m_im;

  logic accept, transfer;

  assign in_ready  = !(count == 2'd3 && full[wr_ptr]);
  assign accept    = in_valid && in_ready;
  assign out_valid = full[rd_ptr];
  assign transfer  = out_valid && out_ready;
  assign out_re    = bank_re[rd_ptr][rd_idx];
  assign out_im    = bank_im[rd_ptr][rd_idx];
  assign out_inv   = bank_inv[rd_ptr];
  assign out_idx   = rd_idx;
  assign out_last  = (rd_idx == 2'd3);

  // The live input is a3; OW = IW+2 leaves room for the worst-case 4x growth.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      s_re[i] = {{2{a_re[i][IW-1]}}, a_re[i]};
      s_im[i] = {{2{a_im[i][IW-1]}}, a_im[i]};
    end
    s_re[3] = {{2{in_re[IW-1]}}, in_re};
    s_im[3] = {{2{in_im[IW-1]}}, in_im};
    e_re  = s_re[0] + s_re[2];
    e_im  = s_im[0] + s_im[2];
    o_re  = s_re[1] + s_re[3];
    o_im  = s_im[1] + s_im[3];
    d0_re = s_re[0] - s_re[2];
    d0_im = s_im[0] - s_im[2];
    d1_re = s_re[1] - s_re[3];
    d1_im = s_im[1] - s_im[3];
    p_re  = d0_re + d1_im;
    p_im  = d0_im - d1_re;
    m_re  = d0_re - d1_im;
    m_im  = d0_im + d1_re;
    x_re[0] = e_re + o_re;
    x_im[0] = e_im + o_im;
    x_re[2] = e_re - o_re;
    x_im[2] = e_im - o_im;
    x_re[1] = frame_inv ? m_re : p_re;
    x_im[1] = frame_inv ? m_im : p_im;
    x_re[3] = frame_inv ? p_re : m_re;
    x_im[3] = frame_inv ? p_im : m_im;
  end

  // A write and a free never target the same bank: writing needs the bank empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      frame_inv <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rd_idx    <= '0;
      full      <= '0;
      bank_inv  <= '0;
      for (int i = 0; i < 3; i++) begin
        a_re[i] <= '0;
        a_im[i] <= '0;
      end
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < 4; i++) begin
          bank_re[b][i] <= '0;
          bank_im[b][i] <= '0;
        end
      end
    end else begin
      if (accept) begin
        if (count == 2'd3) begin
          for (int i = 0; i < 4; i++) begin
            bank_re[wr_ptr][i] <= x_re[i];
            bank_im[wr_ptr][i] <= x_im[i];
          end
          full[wr_ptr]     <= 1'b1;
          bank_inv[wr_ptr] <= frame_inv;
          wr_ptr           <= ~wr_ptr;
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (count == 2'(i)) begin
              a_re[i] <= in_re;
              a_im[i] <= in_im;
            end
          end
          if (count == 2'd0) frame_inv <= in_inv;
        end
        count <= count + 2'd1;
      end
      if (transfer) begin
        rd_idx <= rd_idx + 2'd1;
        if (rd_idx == 2'd3) begin
          full[rd_ptr] <= 1'b0;
          rd_ptr       <= ~rd_ptr;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft4_stream_pp.sv
// Self-checking bench for fft4_stream_pp: a direct DFT model with a bin queue is
// compared against the DUT on every falling clock edge.
module tb_fft4_stream_pp;
  localparam int IW = 8;
  localparam int OW = IW + 2;

  logic          clk, rst, clk_en;
  logic          in_valid, in_ready, in_inv;
  logic [IW-1:0] in_re, in_im;
  logic          out_valid, out_ready, out_last, out_inv;
  logic [OW-1:0] out_re, out_im;
  logic [1:0]    out_idx;

  fft4_stream_pp #(.IW(IW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_inv(in_inv),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_re(out_re), .out_im(out_im), .out_idx(out_idx),
    .out_last(out_last), .out_inv(out_inv)
  );

  always #5 if (clk_en) clk = ~clk;

  typedef struct {int re; int im; int idx; bit inv;} bin_t;
  bin_t q[$];
  int   cur_re[4], cur_im[4];
  int   scnt;
  bit   cur_inv;
  int   errors = 0;
  int   checks = 0;
  bit   accepted;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Textbook DFT: X[k] = sum a[n] * W^(nk), W = -j forward, +j inverse.
  function automatic void dft(input int ar[4], input int ai[4], input bit inv,
                              output int xr[4], output int xi[4]);
    for (int k = 0; k < 4; k++) begin
      xr[k] = 0;
      xi[k] = 0;
      for (int n = 0; n < 4; n++) begin
        int m;
        m = (n * k) % 4;
        if (!inv) m = (4 - m) % 4;
        case (m)
          0: begin xr[k] += ar[n];  xi[k] += ai[n];  end
          1: begin xr[k] -= ai[n];  xi[k] += ar[n];  end
          2: begin xr[k] -= ar[n];  xi[k] -= ai[n];  end
          default: begin xr[k] += ai[n]; xi[k] -= ar[n]; end
        endcase
      end
    end
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
  endfunction

  task automatic model_accept(input int re, input int im, input bit inv);
    int xr[4], xi[4];
    if (scnt == 0) cur_inv = inv;
    cur_re[scnt] = re;
    cur_im[scnt] = im;
    scnt++;
    if (scnt == 4) begin
      dft(cur_re, cur_im, cur_inv, xr, xi);
      for (int k = 0; k < 4; k++) q.push_back('{xr[k], xi[k], k, cur_inv});
      scnt = 0;
    end
  endtask

  task automatic check_outputs();
    int  nframes;
    bin_t e;
    nframes = (q.size() + 3) / 4;
    chk("in_ready", in_ready, !(scnt == 3 && nframes >= 2));
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      e = q[0];
      chk("out_re", int'($signed(out_re)), e.re);
      chk("out_im", int'($signed(out_im)), e.im);
      chk("out_idx", out_idx, e.idx);
      chk("out_last", out_last, e.idx == 3);
      chk("out_inv", out_inv, e.inv);
    end
  endtask

  task automatic step(input bit v, input bit ordy, input bit inv, input int re, input int im);
    @(negedge clk);
    check_outputs();
    in_valid  = v;
    out_ready = ordy;
    in_inv    = inv;
    in_re     = IW'(re);
    in_im     = IW'(im);
    accepted  = v && in_ready;
    if (out_valid && ordy && q.size() > 0) void'(q.pop_front());
    if (accepted) model_accept(re, im, inv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_out_idx", out_idx, 0);
    q.delete();
    scnt = 0;
    #1 rst = 1'b0;
  endtask

  initial begin
    int ar[4], ai[4], xr[4], xi[4];
    int acc;
    clk = 0; clk_en = 0; rst = 0;
    in_valid = 0; in_inv = 0; in_re = '0; in_im = '0; out_ready = 0;
    scnt = 0; cur_inv = 0;

    // Asynchronous reset with the clock stopped
    #1 rst = 1;
    #2;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_re", out_re, 0);
    chk("reset_out_im", out_im, 0);
    chk("reset_out_idx", out_idx, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_out_inv", out_inv, 0);
    #2 rst = 0;
    clk_en = 1;

    // Pin the model with hand-computed bins
    ar = '{1, 2, 3, 4}; ai = '{0, 0, 0, 0};
    dft(ar, ai, 1'b0, xr, xi);
    chk("model_fwd_x0", xr[0], 10);  chk("model_fwd_x1re", xr[1], -2);
    chk("model_fwd_x1im", xi[1], 2); chk("model_fwd_x3im", xi[3], -2);
    dft(ar, ai, 1'b1, xr, xi);
    chk("model_inv_x1im", xi[1], -2); chk("model_inv_x3im", xi[3], 2);
    ar = '{127, 127, 127, 127}; ai = '{-128, -128, -128, -128};
    dft(ar, ai, 1'b0, xr, xi);
    chk("model_ext_x0re", xr[0], 508); chk("model_ext_x0im", xi[0], -512);
    chk("model_ext_x2re", xr[2], 0);

    // Directed forward and inverse frames
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, i + 1, 0);
    idle(6);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i % 2) == 0, i + 1, 0);
    idle(6);

    // Extreme inputs
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, -128, -128);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 127, -128);
    idle(10);

    // Backpressure: two banks plus three samples fill up
    acc = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, 1'($urandom_range(0, 1)), rnd(), rnd());
      if (accepted) acc++;
    end
    chk("bp_accepted", acc, 11);
    chk("bp_in_ready_low", in_ready, 0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, rnd(), rnd());
    idle(16);

    // Full-rate streaming
    for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), rnd(), rnd());
    idle(10);

    // Random valid/ready traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
           1'($urandom_range(0, 1)), rnd(), rnd());
    idle(12);

    // Reset mid-frame and mid-output
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, rnd(), rnd());
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, rnd(), rnd());
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
